neuron_sched: RTL and testbench

NEURON_SCHED -- requirements
Module: neuron_sched

---
 rtl/neuron_sched.sv | 164 ++++++++++++++++
 tb/tb_neuron_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sched.sv
// neuron_sched: time-multiplexes N_NEURON neuron states onto one shared, pipelined neuron datapath.
// Optional per-neuron spike counters (spike_cnt port) are built when NEURON_SCHED_SPIKE_CNT_EN is defined.
module neuron_sched #(
  parameter int N_NEURON = 8,
  parameter int DW = 37,
  parameter logic signed [DW-1:0] V_INIT = DW'(-64'sd545259520)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           num_steps,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  output logic                  in_ready,
  output logic                  dp_valid,
  output logic [DW-1:0]         dp_vn,
  output logic [DW-1:0]         dp_wn,
  output logic [DW-1:0]         dp_in,
  input  logic                  dp_ready,
  input  logic                  res_valid,
  input  logic [DW-1:0]         res_vn,
  input  logic [DW-1:0]         res_wn,
  input  logic                  res_spike,
  output logic [N_NEURON-1:0]   spike_vec,
  output logic                  step_done,
  output logic                  busy,
  output logic                  done,
`ifdef NEURON_SCHED_SPIKE_CNT_EN
  output logic [N_NEURON*16-1:0] spike_cnt,
`endif
  output logic [1:0]            dbg_state,
  output logic                  dbg_proto_err
);

  localparam int IW = $clog2(N_NEURON);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURON - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_STEP_END = 2'd3;

  logic [1:0]          state;
  logic [IW-1:0]       issue_idx;
  logic [IW-1:0]       wb_idx;
  logic [IW:0]         outstanding;
  logic [15:0]         step_cnt;
  logic [15:0]         steps_q;
  logic [N_NEURON-1:0] work_spk;
  logic [DW-1:0]       vn_mem [N_NEURON];
  logic [DW-1:0]       wn_mem [N_NEURON];
  logic                proto_err;
  logic                issue_fire;
  logic                wb_fire;
  logic                start_ok;
  logic                last_issue;

  // Handshake: a transfer happens on any rising edge where valid & ready are both high.
  // In ISSUE the stimulus and datapath channels are fused: in_ready follows dp_ready and
  // dp_valid follows in_valid, so one edge moves a stimulus word straight into the datapath.
  assign in_ready   = (state == S_ISSUE) & dp_ready;
  assign dp_valid   = (state == S_ISSUE) & in_valid;
  assign dp_vn      = vn_mem[issue_idx];
  assign dp_wn      = wn_mem[issue_idx];
  assign dp_in      = in_data;
  assign busy       = (state != S_IDLE);
  assign issue_fire = dp_valid & dp_ready;
  assign wb_fire    = res_valid & (outstanding != '0);
  assign start_ok   = start & (state == S_IDLE);
  assign last_issue = (issue_idx == LAST_IDX);

  assign dbg_state     = state;
  assign dbg_proto_err = proto_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      steps_q   <= '0;
      step_cnt  <= '0;
      spike_vec <= '0;
      step_done <= 1'b0;
      done      <= 1'b0;
    end else begin
      step_done <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            steps_q  <= num_steps;
            step_cnt <= '0;
            if (num_steps == 16'd0) done  <= 1'b1;
            else                    state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_fire && last_issue) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (outstanding == '0) state <= S_STEP_END;
        end
        S_STEP_END: begin
          spike_vec <= work_spk;
          step_done <= 1'b1;
          step_cnt  <= step_cnt + 16'd1;
          // widened compare so a 65535-step run cannot wrap
          if (({1'b0, step_cnt} + 17'd1) < {1'b0, steps_q}) begin
            state <= S_ISSUE;
          end else begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_idx   <= '0;
      wb_idx      <= '0;
      outstanding <= '0;
      work_spk    <= '0;
      proto_err   <= 1'b0;
      for (int i = 0; i < N_NEURON; i++) begin
        vn_mem[i] <= V_INIT;
        wn_mem[i] <= '0;
      end
    end else begin
      if (issue_fire) issue_idx <= last_issue ? '0 : issue_idx + 1'b1;
      case ({issue_fire, wb_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      // a result with nothing in flight is dropped and remembered until reset
      if (res_valid && (outstanding == '0)) proto_err <= 1'b1;
      if (wb_fire) begin
        vn_mem[wb_idx] <= res_vn;
        wn_mem[wb_idx] <= res_wn;
        wb_idx         <= (wb_idx == LAST_IDX) ? '0 : wb_idx + 1'b1;
      end
      if (start_ok || (state == S_STEP_END)) work_spk <= '0;
      else if (wb_fire)                       work_spk[wb_idx] <= res_spike;
    end
  end

`ifdef NEURON_SCHED_SPIKE_CNT_EN
  logic [15:0] cnt_mem [N_NEURON];

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      for (int i = 0; i < N_NEURON; i++) cnt_mem[i] <= '0;
    end else if (wb_fire && res_spike && (cnt_mem[wb_idx] != 16'hFFFF)) begin
      cnt_mem[wb_idx] <= cnt_mem[wb_idx] + 16'd1;
    end
  end

  for (genvar g = 0; g < N_NEURON; g++) begin : g_cnt
    assign spike_cnt[g*16 +: 16] = cnt_mem[g];
  end
`endif

endmodule

// File: tb/tb_neuron_sched.sv
// tb_neuron_sched: table-driven runs plus hand-written reset/restart sequences, all checked
// against a step-level model of neuron state, spike vectors and run bookkeeping.
`timescale 1ns/1ps
module tb_neuron_sched;
  localparam int N  = 8;
  localparam int DW = 37;
  localparam logic [DW-1:0] V_INIT = DW'(-64'sd545259520);

  logic            clk;
  logic            rst;
  logic            start;
  logic [15:0]     num_steps;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            dp_valid;
  logic [DW-1:0]   dp_vn;
  logic [DW-1:0]   dp_wn;
  logic [DW-1:0]   dp_in;
  logic            dp_ready;
  logic            res_valid;
  logic [DW-1:0]   res_vn;
  logic [DW-1:0]   res_wn;
  logic            res_spike;
  logic [N-1:0]    spike_vec;
  logic            step_done;
  logic            busy;
  logic            done;
  logic [1:0]      dbg_state;
  logic            dbg_proto_err;
`ifdef NEURON_SCHED_SPIKE_CNT_EN
  logic [N*16-1:0] spike_cnt;
`endif

  neuron_sched #(.N_NEURON(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dp_valid(dp_valid), .dp_vn(dp_vn), .dp_wn(dp_wn), .dp_in(dp_in), .dp_ready(dp_ready),
    .res_valid(res_valid), .res_vn(res_vn), .res_wn(res_wn), .res_spike(res_spike),
    .spike_vec(spike_vec), .step_done(step_done), .busy(busy), .done(done),
`ifdef NEURON_SCHED_SPIKE_CNT_EN
    .spike_cnt(spike_cnt),
`endif
    .dbg_state(dbg_state), .dbg_proto_err(dbg_proto_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] vn;
    logic [DW-1:0] wn;
    logic          spk;
    int            k;
    int            due;
    int            gen;
    bit            last;
  } dp_t;

  typedef struct {
    logic [15:0] steps;
    int          lat;
    int          rdy;
    bit          vrand;
    bit          srand;
    logic [N-1:0] mask;
    int          poke;
    int          exp_sd;
    int          exp_done;
    int          exp_iss;
    bit          chk_vec;
    logic [N-1:0] exp_vec;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus controls
  int           lat = 1;
  int           rdy_mode = 0;
  bit           vld_rand = 0;
  bit           spk_rand = 0;
  logic [N-1:0] spk_mask = '0;
  int           rst_at_issue = 0;
  bit           start_pend = 0;
  logic [15:0]  steps_cmd = '0;
  int           rst_cnt = 0;
  bit           last_xfer = 0;
  bit           rst_hit = 0;

  // reference model
  logic [DW-1:0] ref_vn [N];
  logic [DW-1:0] ref_wn [N];
  int            ref_cnt [N];
  logic [N-1:0]  exp_q [$];
  logic [N-1:0]  spk_of_step [$];
  dp_t           dpq [$];
  logic [N-1:0]  cur_spk = '0;
  bit            run_active = 0;
  bit            issue_phase = 0;
  bit            done_exp_next = 0;
  int            steps_total = 0;
  int            steps_seen = 0;
  int            iss_idx = 0;
  int            run_issues = 0;
  int            gen = 0;
  int            n_step_done = 0;
  int            n_done = 0;
  int            n_issue = 0;
  int            max_inflight = 0;
  logic [N-1:0]  last_vec = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ref_vn[i]  = V_INIT;
      ref_wn[i]  = '0;
      ref_cnt[i] = 0;
    end
    exp_q.delete();
    spk_of_step.delete();
    run_active    = 0;
    issue_phase   = 0;
    done_exp_next = 0;
    iss_idx       = 0;
    cur_spk       = '0;
    gen++;
  endtask

  // driver: all DUT inputs change here, half a cycle away from the sampling edge
  task automatic drive_inputs();
    dp_t e;
    rst = (rst_cnt > 0);
    if (rst_cnt > 0) rst_cnt--;
    start      = start_pend;
    start_pend = 0;
    num_steps  = steps_cmd;
    case (rdy_mode)
      0:       dp_ready = 1'b1;
      1:       dp_ready = ~dp_ready;
      default: dp_ready = 1'($urandom_range(0, 1));
    endcase
    if (!in_valid || last_xfer) begin
      in_valid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = rnd_word();
    end
    res_valid = 1'b0;
    if (dpq.size() > 0 && dpq[0].due <= cyc) begin
      e = dpq.pop_front();
      res_valid = 1'b1;
      res_vn    = e.vn;
      res_wn    = e.wn;
      res_spike = e.spk;
      if (e.gen == gen) begin
        if (e.spk && ref_cnt[e.k] < 65535) ref_cnt[e.k]++;
        if (e.last) exp_q.push_back(spk_of_step.pop_front());
      end
    end
  endtask

  task automatic check_outputs();
    bit final_now;
    final_now = 0;
    if (step_done) begin
      n_step_done++;
      if (exp_q.size() == 0) chk("step_done_before_writeback", 1, 0);
      else                   chk("spike_vec", spike_vec, exp_q.pop_front());
      last_vec = spike_vec;
      steps_seen++;
      if (steps_seen < steps_total) issue_phase = 1;
      else begin
        final_now  = 1;
        run_active = 0;
      end
    end
    if (done) n_done++;
    chk("done", done, final_now || done_exp_next);
    done_exp_next = 0;
    chk("busy", busy, run_active);
    if (issue_phase) begin
      chk("in_ready_mirror", in_ready, dp_ready);
      chk("dp_valid_mirror", dp_valid, in_valid);
    end else begin
      chk("in_ready_quiet", in_ready, 0);
      chk("dp_valid_quiet", dp_valid, 0);
    end
  endtask

  task automatic process_events();
    dp_t e;
    bit  xfer;
    int  k;
    xfer      = dp_valid && dp_ready;
    last_xfer = 0;
    if (rst_at_issue != 0 && xfer && (run_issues + 1) == rst_at_issue) begin
      rst          = 1'b1;
      rst_at_issue = 0;
      rst_hit      = 1;
    end
    if (rst) begin
      model_reset();
    end else begin
      if (start && !run_active) begin
        run_issues  = 0;
        steps_seen  = 0;
        steps_total = int'(num_steps);
        cur_spk     = '0;
        for (int i = 0; i < N; i++) ref_cnt[i] = 0;
        if (num_steps == 16'd0) done_exp_next = 1;
        else begin
          run_active  = 1;
          issue_phase = 1;
        end
      end
      if (xfer) begin
        k = iss_idx;
        chk("dp_vn", dp_vn, ref_vn[k]);
        chk("dp_wn", dp_wn, ref_wn[k]);
        chk("dp_in", dp_in, in_data);
        e.vn   = dp_vn + dp_in;
        e.wn   = dp_wn + 1'b1;
        e.spk  = spk_rand ? 1'($urandom_range(0, 1)) : spk_mask[k];
        e.k    = k;
        e.gen  = gen;
        e.due  = cyc + lat;
        e.last = (k == N - 1);
        ref_vn[k]  = ref_vn[k] + in_data;
        ref_wn[k]  = ref_wn[k] + 1'b1;
        cur_spk[k] = e.spk;
        if (e.last) begin
          spk_of_step.push_back(cur_spk);
          cur_spk     = '0;
          issue_phase = 0;
          iss_idx     = 0;
        end else begin
          iss_idx++;
        end
        dpq.push_back(e);
        if (dpq.size() > max_inflight) max_inflight = dpq.size();
        n_issue++;
        run_issues++;
        last_xfer = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    drive_inputs();
    #2;
    check_outputs();
    process_events();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int sd0, d0, i0, t;
    sd0 = n_step_done;
    d0  = n_done;
    i0  = n_issue;
    lat = (v.lat == 0) ? $urandom_range(1, 6) : v.lat;
    rdy_mode = v.rdy;
    vld_rand = v.vrand;
    spk_rand = v.srand;
    spk_mask = v.mask;
    max_inflight = 0;
    steps_cmd  = v.steps;
    start_pend = 1;
    t = 0;
    while (n_done == d0 && t < 3000) begin
      cycle();
      t++;
      if (v.poke != 0 && t == v.poke) begin
        steps_cmd  = 16'd7;
        start_pend = 1;
      end
    end
    chk({tag, "_timeout"}, (n_done != d0), 1);
    t = 0;
    while (dpq.size() > 0 && t < 100) begin
      cycle();
      t++;
    end
    cycle();
    cycle();
    chk({tag, "_step_dones"}, n_step_done - sd0, v.exp_sd);
    chk({tag, "_dones"}, n_done - d0, v.exp_done);
    chk({tag, "_issues"}, n_issue - i0, v.exp_iss);
    if (v.chk_vec) chk({tag, "_last_spike_vec"}, last_vec, v.exp_vec);
`ifdef NEURON_SCHED_SPIKE_CNT_EN
    for (int i = 0; i < N; i++) chk({tag, "_spike_cnt"}, spike_cnt[i*16 +: 16], ref_cnt[i]);
`endif
  endtask

  vec_t vt [9];
  vec_t v_rerun;

  initial begin
    int t;
    int d0;
    rst = 1'b1; start = 1'b0; num_steps = '0; in_valid = 1'b0; in_data = '0;
    dp_ready = 1'b0; res_valid = 1'b0; res_vn = '0; res_wn = '0; res_spike = 1'b0;
    model_reset();
    rst_cnt = 3;
    for (int i = 0; i < 5; i++) cycle();
    chk("reset_spike_vec", spike_vec, 0);
    chk("reset_step_done", step_done, 0);
    chk("reset_proto_err", dbg_proto_err, 0);

    //          steps  lat rdy vrand srand mask   poke sd done iss chk   vec
    vt[0] = '{16'd1, 1,  0, 1'b0, 1'b0, 8'h08, 0,  1, 1,  8, 1'b1, 8'h08};
    vt[1] = '{16'd0, 1,  0, 1'b0, 1'b0, 8'h00, 0,  0, 1,  0, 1'b0, 8'h00};
    vt[2] = '{16'd2, 1,  1, 1'b0, 1'b0, 8'h81, 0,  2, 1, 16, 1'b1, 8'h81};
    vt[3] = '{16'd2, 5,  0, 1'b0, 1'b0, 8'hff, 0,  2, 1, 16, 1'b1, 8'hff};
    vt[4] = '{16'd2, 2,  2, 1'b1, 1'b0, 8'h5a, 6,  2, 1, 16, 1'b1, 8'h5a};
    vt[5] = '{16'd3, 0,  2, 1'b1, 1'b1, 8'h00, 0,  3, 1, 24, 1'b0, 8'h00};
    vt[6] = '{16'd3, 0,  2, 1'b1, 1'b1, 8'h00, 0,  3, 1, 24, 1'b0, 8'h00};
    vt[7] = '{16'd3, 0,  2, 1'b1, 1'b1, 8'h00, 0,  3, 1, 24, 1'b0, 8'h00};
    vt[8] = '{16'd4, 1,  0, 1'b0, 1'b0, 8'h01, 0,  4, 1, 32, 1'b1, 8'h01};

    for (int i = 0; i < 9; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
      if (i == 3) chk("vec3_max_outstanding", max_inflight, 5);
    end
    chk("proto_err_clean_runs", dbg_proto_err, 0);

    // reset landing on the 4th issue of step 2 of a 3-step run
    rst_hit = 0;
    lat = 4; rdy_mode = 0; vld_rand = 0; spk_rand = 0; spk_mask = 8'h24;
    rst_at_issue = 12;
    d0 = n_done;
    steps_cmd  = 16'd3;
    start_pend = 1;
    t = 0;
    while (!rst_hit && t < 500) begin
      cycle();
      t++;
    end
    chk("rst_trigger_reached", rst_hit, 1);
    rst_at_issue = 0;
    cycle();
    chk("busy_after_rst", busy, 0);
    t = 0;
    while (dpq.size() > 0 && t < 50) begin
      cycle();
      t++;
    end
    cycle();
    cycle();
    chk("no_done_after_rst", n_done - d0, 0);
    chk("proto_err_after_stale_results", dbg_proto_err, 1);

    v_rerun = '{16'd3, 3, 2, 1'b1, 1'b0, 8'h24, 0, 3, 1, 24, 1'b1, 8'h24};
    run_vec(v_rerun, "rerun_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
